// File: rtl/scan_chain_bist.sv
// rtl/scan_chain_bist.sv - scan-chain single-pulse self-test engine
//
// Purpose:
//   Flushes the scan chain with zeros and injects a single '1' at sc_head.
//   It then checks that the pulse reaches sc_tail after exactly
//   SCAN_CHAIN_SIZE shifts, and that zeros follow it for POST_CHECK cycles.
//   It reports done/pass and a saturating mismatch count.
//
// Optional feature (macro SCAN_BIST_ERRLOG_EN):
//   Adds first_err_cyc, which records the phase (MSB: 0=SHIFT, 1=POST) and
//   the counter value of the first mismatch.
//
// Ports:
//   clk           in   operating clock; also shifts the scan chain
//   Reset_n       in   asynchronous active-low reset
//   start         in   level-sampled launch request (honoured in IDLE/DONE)
//   sc_head       out  scan-chain head drive (registered)
//   sc_tail       in   scan-chain tail, sampled on rising clk
//   Test_en       out  scan enable to fabric, high while the test runs
//   busy          out  high in FLUSH/INJECT/SHIFT/POST
//   done          out  high in DONE, sticky until relaunch or reset
//   pass          out  done with zero mismatches
//   err_count     out  mismatch count, saturating at 8'hFF
//   first_err_cyc out  [CNT_W:0] first-error phase/counter (SCAN_BIST_ERRLOG_EN only)

module scan_chain_bist #(
  parameter int SCAN_CHAIN_SIZE = 2304,
  parameter int POST_CHECK      = 2,
  parameter int CNT_W           = 12
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic             sc_head,
  input  logic             sc_tail,
  output logic             Test_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count
`ifdef SCAN_BIST_ERRLOG_EN
  ,
  output logic [CNT_W:0]   first_err_cyc
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    INJECT = 3'd2,
    SHIFT  = 3'd3,
    POST   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CHAIN_LEN  = CNT_W'(SCAN_CHAIN_SIZE);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SCAN_CHAIN_SIZE - 1);
  localparam logic [CNT_W-1:0] POST_LEN   = CNT_W'(POST_CHECK);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       err_next;
  logic             err_hit;
  logic             launch;
  logic             busy_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_hit    = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_next = INJECT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      INJECT: begin
        // The edge leaving INJECT clocks the pulse into flop0, so the
        // count of shifts seen by the pulse starts at 1.
        state_next = SHIFT;
        cnt_next   = CNT_W'(1);
      end
      SHIFT: begin
        if (cnt < CHAIN_LEN) begin
          err_hit  = sc_tail;            // pulse arrived early
          cnt_next = cnt + 1'b1;
        end else begin
          err_hit    = ~sc_tail;         // pulse missing at the expected shift
          state_next = POST;
          cnt_next   = CNT_W'(1);
        end
      end
      POST: begin
        err_hit = sc_tail;               // tail must stay clean after the pulse
        if (cnt == POST_LEN) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (launch) begin
      err_next = 8'h00;
    end else if (err_hit && (err_count != 8'hFF)) begin
      err_next = err_count + 8'h01;
    end else begin
      err_next = err_count;
    end

    busy_next = (state_next == FLUSH) || (state_next == INJECT) ||
                (state_next == SHIFT) || (state_next == POST);
  end

  // Outputs are flopped from next-state values, so they line up with the
  // state register and have no combinational path from inputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_count <= 8'h00;
      sc_head   <= 1'b0;
      Test_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      err_count <= err_next;
      sc_head   <= (state_next == INJECT);
      Test_en   <= busy_next;
      busy      <= busy_next;
      done      <= (state_next == DONE);
      pass      <= (state_next == DONE) && (err_next == 8'h00);
    end
  end

`ifdef SCAN_BIST_ERRLOG_EN
  // err_count never returns to zero without a launch (it saturates), so
  // "err_count == 0" identifies the first error of a run.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      first_err_cyc <= '0;
    end else if (launch) begin
      first_err_cyc <= '0;
    end else if (err_hit && (err_count == 8'h00)) begin
      first_err_cyc <= {(state == POST), cnt};
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_bist.sv
// tb/tb_scan_chain_bist.sv - directed self-checking bench for scan_chain_bist

module tb_scan_chain_bist;

  logic       clk;
  logic       Reset_n;
  logic       start;
  logic       sc_head;
  logic       sc_tail;
  logic       Test_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;

  logic       start2;
  logic       sc_head2;
  logic       Test_en2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [7:0] err_count2;

`ifdef SCAN_BIST_ERRLOG_EN
  logic [12:0] first_err_cyc;
  logic [12:0] first_err_cyc2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Chain model: 0 ideal 8 flops, 1 short 7 flops, 2 stuck-0, 3 stuck-1.
  int          mode = 0;
  logic [15:0] chain = '0;

  always @(posedge clk) chain <= {chain[14:0], sc_head};

  always_comb begin
    sc_tail = 1'b0;
    case (mode)
      0:       sc_tail = chain[7];
      1:       sc_tail = chain[6];
      2:       sc_tail = 1'b0;
      default: sc_tail = 1'b1;
    endcase
  end

  scan_chain_bist #(.SCAN_CHAIN_SIZE(8), .POST_CHECK(2), .CNT_W(12)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .sc_head   (sc_head),
    .sc_tail   (sc_tail),
    .Test_en   (Test_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef SCAN_BIST_ERRLOG_EN
    ,
    .first_err_cyc (first_err_cyc)
`endif
  );

  scan_chain_bist #(.SCAN_CHAIN_SIZE(300), .POST_CHECK(2), .CNT_W(12)) dut_sat (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .start     (start2),
    .sc_head   (sc_head2),
    .sc_tail   (1'b1),
    .Test_en   (Test_en2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err_count2)
`ifdef SCAN_BIST_ERRLOG_EN
    ,
    .first_err_cyc (first_err_cyc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one launch edge; returns #1 after that edge.
  task automatic launch_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the launch edge until done, with a bound.
  task automatic wait_done(output int lat, output int head_cnt,
                           output int head_at, output bit busy_ok);
    lat = 0; head_cnt = 0; head_at = -1; busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (sc_head) begin head_cnt++; head_at = lat; end
      if (!done && (!busy || !Test_en)) busy_ok = 1'b0;
    end while (!done && lat < 200);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass); end
    n_tests++; if (Test_en !== 1'b0) begin n_fail++; $display("FAIL reset_test_en got %b want 0", Test_en); end
    n_tests++; if (sc_head !== 1'b0) begin n_fail++; $display("FAIL reset_sc_head got %b want 0", sc_head); end
    n_tests++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h want 00", err_count); end
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_ideal();
    int lat, hc, ha; bit bok;
    mode = 0;
    launch_pulse();
    n_tests++; if (Test_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ideal_start te=%b busy=%b want 1 1", Test_en, busy); end
    wait_done(lat, hc, ha, bok);
    n_tests++; if (lat != 19) begin n_fail++; $display("FAIL ideal_latency got %0d want 19", lat); end
    n_tests++; if (!bok) begin n_fail++; $display("FAIL ideal_busy_gap got 0 want 1"); end
    n_tests++; if (hc != 1 || ha != 8) begin n_fail++; $display("FAIL ideal_inject got cnt=%0d at=%0d want 1 at 8", hc, ha); end
    n_tests++; if (pass !== 1'b1 || err_count !== 8'h00) begin n_fail++; $display("FAIL ideal_result pass=%b err=%h want 1 00", pass, err_count); end
    n_tests++; if (busy !== 1'b0 || Test_en !== 1'b0) begin n_fail++; $display("FAIL ideal_idle busy=%b te=%b want 0 0", busy, Test_en); end
`ifdef SCAN_BIST_ERRLOG_EN
    n_tests++; if (first_err_cyc !== 13'h0) begin n_fail++; $display("FAIL ideal_errlog got %h want 0000", first_err_cyc); end
`endif
  endtask

  task automatic test_short_chain();
    int lat, hc, ha; bit bok;
    mode = 1;
    launch_pulse();
    wait_done(lat, hc, ha, bok);
    n_tests++; if (err_count !== 8'd2 || pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL short_result err=%0d pass=%b done=%b want 2 0 1", err_count, pass, done); end
`ifdef SCAN_BIST_ERRLOG_EN
    n_tests++; if (first_err_cyc !== {1'b0, 12'd7}) begin n_fail++; $display("FAIL short_errlog got %h want 0007", first_err_cyc); end
`endif
  endtask

  task automatic test_stuck0();
    int lat, hc, ha; bit bok;
    mode = 2;
    launch_pulse();
    wait_done(lat, hc, ha, bok);
    n_tests++; if (err_count !== 8'd1 || pass !== 1'b0) begin n_fail++; $display("FAIL stuck0_result err=%0d pass=%b want 1 0", err_count, pass); end
`ifdef SCAN_BIST_ERRLOG_EN
    n_tests++; if (first_err_cyc !== {1'b0, 12'd8}) begin n_fail++; $display("FAIL stuck0_errlog got %h want 0008", first_err_cyc); end
`endif
  endtask

  task automatic test_stuck1();
    int lat, hc, ha; bit bok;
    mode = 3;
    launch_pulse();
    wait_done(lat, hc, ha, bok);
    n_tests++; if (err_count !== 8'd9 || pass !== 1'b0) begin n_fail++; $display("FAIL stuck1_result err=%0d pass=%b want 9 0", err_count, pass); end
`ifdef SCAN_BIST_ERRLOG_EN
    n_tests++; if (first_err_cyc !== {1'b0, 12'd1}) begin n_fail++; $display("FAIL stuck1_errlog got %h want 0001", first_err_cyc); end
`endif
  endtask

  task automatic test_async_reset();
    int lat, hc, ha; bit bok;
    mode = 3;
    launch_pulse();
    // Counter reaches 4 in SHIFT after 12 edges past launch; 3 errors so far.
    repeat (12) @(posedge clk);
    #1;
    n_tests++; if (err_count !== 8'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL midrun_err err=%0d busy=%b want 3 1", err_count, busy); end
    #2;
    Reset_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || Test_en !== 1'b0 || sc_head !== 1'b0 || err_count !== 8'h00 || pass !== 1'b0)
      begin n_fail++; $display("FAIL async_reset busy=%b done=%b te=%b head=%b err=%h pass=%b want all 0", busy, done, Test_en, sc_head, err_count, pass); end
    @(negedge clk);
    Reset_n = 1'b1;
    mode = 0;
    launch_pulse();
    wait_done(lat, hc, ha, bok);
    n_tests++; if (lat != 19 || pass !== 1'b1) begin n_fail++; $display("FAIL post_reset_run lat=%0d pass=%b want 19 1", lat, pass); end
  endtask

  task automatic test_back_to_back();
    int lat, hc, ha; bit bok;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, hc, ha, bok);
    n_tests++; if (lat != 19 || err_count !== 8'd1) begin n_fail++; $display("FAIL held_first lat=%0d err=%0d want 19 1", lat, err_count); end
    mode = 0;
    @(posedge clk);
    #1;
    n_tests++; if (done !== 1'b0 || busy !== 1'b1 || err_count !== 8'h00) begin n_fail++; $display("FAIL relaunch done=%b busy=%b err=%h want 0 1 00", done, busy, err_count); end
    wait_done(lat, hc, ha, bok);
    start = 1'b0;
    n_tests++; if (lat != 19 || pass !== 1'b1 || !bok) begin n_fail++; $display("FAIL held_second lat=%0d pass=%b busy_ok=%b want 19 1 1", lat, pass, bok); end
    @(posedge clk);
    #1;
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_sticky done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_saturation();
    int lat;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done2 && lat < 2000);
    n_tests++; if (lat != 603) begin n_fail++; $display("FAIL sat_latency got %0d want 603", lat); end
    n_tests++; if (err_count2 !== 8'hFF || pass2 !== 1'b0) begin n_fail++; $display("FAIL sat_err err=%h pass=%b want ff 0", err_count2, pass2); end
`ifdef SCAN_BIST_ERRLOG_EN
    n_tests++; if (first_err_cyc2 !== {1'b0, 12'd1}) begin n_fail++; $display("FAIL sat_errlog got %h want 0001", first_err_cyc2); end
`endif
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_short_chain();
    test_stuck0();
    test_stuck1();
    test_async_reset();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
